// File: rtl/pp_pipeline_accel_arb_pkg.sv
// rtl/pp_pipeline_accel_arb_pkg.sv - shared types and helpers for pp_pipeline_accel arbiters
// Purpose: arbiter state enum, default burst length, pointer width helper.
// Ports: none (package).
package pp_pipeline_accel_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int ARB_DEFAULT_MAX_BURST = 16;

    // Index width for n items; never narrower than one bit.
    function automatic int arb_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pp_pipeline_accel_rr_pick.sv
// rtl/pp_pipeline_accel_rr_pick.sv - combinational one-hot round-robin selector
// Purpose: pick the first set request at or above ptr, wrapping to index 0.
// Ports:
//   req         in  N_REQ  request vector
//   ptr         in  PTR_W  search start index
//   pick_onehot out N_REQ  one-hot winner (0 when no request)
//   pick_idx    out PTR_W  winner index
//   pick_valid  out 1      any request present
module pp_pipeline_accel_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [PTR_W-1:0] pick_idx,
    output logic             pick_valid
);

    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_valid  = 1'b0;
        // Pass 1: lowest set bit overall, used when nothing sits at/above ptr.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_idx       = PTR_W'(i);
                pick_valid     = 1'b1;
            end
        end
        // Pass 2: lowest set bit at/above ptr overrides the wrapped choice.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_idx       = PTR_W'(i);
                pick_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pp_pipeline_accel_fifo_wr_arb.sv
// rtl/pp_pipeline_accel_fifo_wr_arb.sv - round-robin burst arbiter for a stream FIFO write port
// Purpose: share one FIFO write side (full_n/write/din) among N_REQ producers,
//   holding each grant until the owner's last beat or MAX_BURST beats.
// Optional: define ARB_STATS_EN for saturating per-requester beat counters.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   req_valid    in  N_REQ             per-requester beat valid
//   req_last     in  N_REQ             end-of-burst marker, qualified by req_valid
//   req_din      in  N_REQ*DATA_WIDTH  flattened beats, slice i for requester i
//   req_ready    out N_REQ             per-requester beat accepted
//   fifo_full_n  in  1                 FIFO not full
//   fifo_write   out 1                 FIFO write strobe
//   fifo_din     out DATA_WIDTH        FIFO write data
//   grant        out N_REQ             registered one-hot owner, 0 when idle
//   busy         out 1                 burst in progress
//   beat_cnt     out N_REQ*CNT_WIDTH   accepted-beat counters (ARB_STATS_EN only)
module pp_pipeline_accel_fifo_wr_arb
    import pp_pipeline_accel_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = ARB_DEFAULT_MAX_BURST,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_din,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full_n,
    output logic                        fifo_write,
    output logic [DATA_WIDTH-1:0]       fifo_din,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_WIDTH-1:0]  beat_cnt
`endif
);

    localparam int PTR_W  = arb_width(N_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("pp_pipeline_accel_fifo_wr_arb: parameter out of range");
    end

    arb_state_e             state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;

    logic [N_REQ-1:0]       pick_onehot;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [DATA_WIDTH-1:0]  owner_din;
    logic                   accept;
    logic                   last_hit;

    pp_pipeline_accel_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req         (req_valid),
        .ptr         (ptr_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    // grant_q is zero outside a burst, so the data mux and accept need no state term.
    always_comb begin
        owner_din = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_din = req_din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept     = (|(req_valid & grant_q)) & fifo_full_n;
    assign last_hit   = |(req_valid & req_last & grant_q);
    assign req_ready  = fifo_full_n ? grant_q : '0;
    assign fifo_write = accept;
    assign fifo_din   = owner_din;
    assign grant      = grant_q;
    assign busy       = (state_q == ARB_BURST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BURST;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    bcnt_d  = '0;
                end
            end
            ARB_BURST: begin
                // Stalls (no accept) never end or rotate a burst.
                if (accept) begin
                    if (last_hit || (bcnt_q == BCNT_LAST)) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        bcnt_d  = '0;
                        ptr_d   = (owner_q == PTR_MAX) ? '0 : owner_q + PTR_W'(1);
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [N_REQ*CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept && grant_q[i] && (beat_cnt_q[i*CNT_WIDTH +: CNT_WIDTH] != '1)) begin
                beat_cnt_d[i*CNT_WIDTH +: CNT_WIDTH] =
                    beat_cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_wr_arb.sv
// tb/tb_pp_pipeline_accel_fifo_wr_arb.sv - self-checking bench for pp_pipeline_accel_fifo_wr_arb
module tb_pp_pipeline_accel_fifo_wr_arb;

    localparam int N  = 2;
    localparam int DW = 64;
    localparam int MB = 16;
    localparam int CW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_din;
    logic [N-1:0]    req_ready;
    logic            fifo_full_n;
    logic            fifo_write;
    logic [DW-1:0]   fifo_din;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef ARB_STATS_EN
    logic [N*CW-1:0] beat_cnt;
`endif

    pp_pipeline_accel_fifo_wr_arb #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_din     (req_din),
        .req_ready   (req_ready),
        .fifo_full_n (fifo_full_n),
        .fifo_write  (fifo_write),
        .fifo_din    (fifo_din),
        .grant       (grant),
        .busy        (busy)
`ifdef ARB_STATS_EN
        ,
        .beat_cnt    (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: current owner (-1 = nobody), next search start,
    // beats accepted in the running burst.
    int m_owner;
    int m_ptr;
    int m_beats;
    int seq   [N];
    int sent  [N];
    int stat  [N];
    int dut_writes;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        for (int i = 0; i < N; i++) stat[i] = 0;
    endtask

    task automatic start_mode();
        for (int i = 0; i < N; i++) sent[i] = 0;
        dut_writes = 0;
    endtask

    // mode 1: req0 alone, last on its 4th beat
    // mode 2: all valid, never last
    // mode 3: all valid, FIFO full for cycles 8..12 of the run
    // mode 4: all valid, last on the 16th beat of every burst
    // mode 5: random valid/last/full_n
    task automatic drive(input int mode, input int cyc);
        fifo_full_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_din[i*DW +: DW] = {32'(i + 1), 32'(seq[i])};
            case (mode)
                1: begin
                    req_valid[i] = (i == 0);
                    req_last[i]  = (i == 0) && (sent[0] == 3);
                end
                2, 3: begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = 1'b0;
                end
                4: begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = (m_owner == i) && (m_beats == MB - 1);
                end
                5: begin
                    req_valid[i] = ($urandom % 4) != 0;
                    req_last[i]  = ($urandom % 6) == 0;
                end
                default: begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            endcase
        end
        if (mode == 3) fifo_full_n = !(cyc >= 8 && cyc <= 12);
        if (mode == 5) fifo_full_n = ($urandom % 5) != 0;
    endtask

    task automatic step(input int mode, input int cyc);
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_ready;
        logic          e_write;
        logic [DW-1:0] e_din;
        bit            found;
        int            c;
        drive(mode, cyc);
        #1;
        e_grant = '0;
        e_ready = '0;
        e_write = 1'b0;
        e_din   = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_ready[m_owner] = fifo_full_n;
            e_write          = req_valid[m_owner] && fifo_full_n;
            e_din            = req_din[m_owner*DW +: DW];
        end
        check_eq("grant", 64'(grant), 64'(e_grant));
        check_eq("busy", 64'(busy), 64'(m_owner >= 0));
        check_eq("req_ready", 64'(req_ready), 64'(e_ready));
        check_eq("fifo_write", 64'(fifo_write), 64'(e_write));
        check_eq("fifo_din", fifo_din, e_din);
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check_eq("beat_cnt", 64'(beat_cnt[i*CW +: CW]), 64'(stat[i]));
`endif
        if (fifo_write) dut_writes++;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && req_valid[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_beats = 0;
                end
            end
        end else if (e_write) begin
            seq[m_owner]++;
            sent[m_owner]++;
            if (stat[m_owner] < (1 << CW) - 1) stat[m_owner]++;
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int mode, input int n);
        start_mode();
        for (int cyc = 0; cyc < n; cyc++) step(mode, cyc);
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        reset       = 1'b1;
        req_valid   = '0;
        req_last    = '0;
        req_din     = '0;
        fifo_full_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_write", 64'(fifo_write), 64'd0);
        check_eq("rst_din", fifo_din, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run(1, 5);
        check_eq("single_burst_writes", 64'(dut_writes), 64'd4);
        run(2, 68);
        check_eq("alt_burst_writes", 64'(dut_writes), 64'd64);
        run(3, 22);
        check_eq("stall_burst_writes", 64'(dut_writes), 64'd16);
        run(4, 34);
        check_eq("last_max_writes", 64'(dut_writes), 64'd32);

        // Asynchronous reset three beats into a burst.
        run(2, 4);
        #2;
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("async_grant", 64'(grant), 64'd0);
        check_eq("async_busy", 64'(busy), 64'd0);
        check_eq("async_write", 64'(fifo_write), 64'd0);
        check_eq("async_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(2, 1);
        check_eq("post_rst_grant", 64'(grant), 64'd1);
        run(2, 16);

        run(5, 800);
        run(0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_pipeline_accel_fifo_wr_arb.md
Name: pp_pipeline_accel_fifo_wr_arb

Overview:
- Round-robin write-port arbiter: lets N_REQ producer streams share the write side of one pp_pipeline_accel stream FIFO (if_full_n / if_write / if_din style).
- Grants one requester at a time and holds the grant for a burst: until that requester's last beat or MAX_BURST beats, whichever comes first.
- Sits between the producer stages and the FIFO instance; the FIFO read side is untouched.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 64, beat width; matches FIFO DATA_WIDTH.
- MAX_BURST, 16, maximum beats per grant before forced rotation (>=1).
- CNT_WIDTH, 16, width of the optional statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester end-of-burst marker, qualified by req_valid.
- req_din  in  N_REQ*DATA_WIDTH  flattened beats; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  N_REQ  per-requester beat accepted.
- fifo_full_n  in  1  FIFO if_full_n.
- fifo_write  out  1  to FIFO if_write; if_write_ce is tied 1 externally.
- fifo_din  out  DATA_WIDTH  to FIFO if_din.
- grant  out  N_REQ  registered one-hot current owner; 0 when idle.
- busy  out  1  high in BURST state.
- beat_cnt  out  N_REQ*CNT_WIDTH  per-requester accepted-beat counters. Present only with ARB_STATS_EN.

Behaviour:
- Reset: clk and reset only; reset is asynchronous and active-high.
  - While reset is high, or after it: state=IDLE, grant=0, busy=0, req_ready=0, fifo_write=0, fifo_din=0.
  - Round-robin pointer=0, burst counter=0.
- States:
  - IDLE: no grant. If any req_valid is set, pick the first set bit searching from the pointer upward with wrap. Register it into grant; next state BURST. If no req_valid is set, stay in IDLE.
  - BURST, owner g:
    - req_ready[g]=fifo_full_n; all other req_ready=0.
    - fifo_write=req_valid[g] & fifo_full_n; fifo_din=req_din slice g (combinational mux).
    - A beat is accepted when req_valid[g] & fifo_full_n.
    - On accept, burst counter += 1.
    - On an accepted beat that has req_last[g]=1, or when the counter equals MAX_BURST-1: next state IDLE, grant=0, counter=0, pointer=(g+1) mod N_REQ.
- Latency:
  - One idle arbitration cycle between bursts, so peak throughput is MAX_BURST/(MAX_BURST+1) of FIFO bandwidth.
  - Inside a burst: one beat per clk while full_n=1.
- Backpressure: when fifo_full_n=0, no beat is accepted and the counter holds. The grant is kept; rotation never happens mid-stall.
- Owner drop: req_valid[g] falling mid-burst keeps the grant (the burst stays locked); only last or MAX_BURST ends it.
- Simultaneous last and MAX_BURST on the same beat: a single exit to IDLE, one pointer advance.
- MAX_BURST=1: every accepted beat returns to IDLE.
- A requester whose req_valid is low during arbitration is skipped, and gains nothing.
- Reset mid-burst: the block returns immediately to reset values. A partially written burst in the FIFO is not rolled back; the FIFO shares the same reset.
- Width rules:
  - Burst counter width = $clog2(MAX_BURST+1).
  - Pointer width = $clog2(N_REQ), minimum 1.
  - The pointer wraps by explicit compare against N_REQ-1, not by overflow.

Optional Feature:
- ARB_STATS_EN defined: beat_cnt port exists. Counter i increments on each accepted beat of requester i, saturates at all-ones, and is cleared by reset.
- Not defined: no port, no counters; the logic is otherwise identical.

Decomposition:
- Shared package pp_pipeline_accel_arb_pkg holds:
  - state enum typedef {ARB_IDLE, ARB_BURST};
  - a clog2-based width function;
  - the default MAX_BURST constant.
- One sub-module: pp_pipeline_accel_rr_pick, a combinational one-hot round-robin selector taking req vector and pointer and returning one-hot plus index. Reused by other accel arbiters.

Test Plan:
- Reset, then req_valid=01, 4 beats with last on beat 4, full_n=1:
  - grant=01 from cycle 2;
  - fifo_write high on cycles 2-5;
  - IDLE on cycle 6;
  - pointer=1.
- Both requesters continuously valid, no last, MAX_BURST=16:
  - alternating 16-beat bursts 0,1,0,1 with one gap cycle each;
  - FIFO data order matches the requester tags.
- Hold full_n=0 for 5 cycles mid-burst at beat 7:
  - no fifo_write, req_ready=0, grant held;
  - burst resumes at beat 8;
  - total still 16 beats.
- last asserted on beat 16 (MAX_BURST=16):
  - single exit, pointer advances by exactly 1;
  - the next grant goes to the other requester.
- Assert reset asynchronously at beat 3 of a burst:
  - grant/busy/fifo_write drop without a clock edge;
  - after release, arbitration restarts from requester 0.
- ARB_STATS_EN: 20 beats from req0 and 5 from req1 -> beat_cnt0=20, beat_cnt1=5; a forced near-max value saturates at 0xFFFF.
